// File: rtl/dtree_pkg.sv
// Shared definitions for the dtree classifier and its downstream stages:
// class geometry, the class-id mapping and the dump FSM state type.
package dtree_pkg;

    localparam int unsigned LEVEL_WIDTH = 2;
    localparam int unsigned PATH_WIDTH  = 2;
    localparam int unsigned CLASS_WIDTH = LEVEL_WIDTH + PATH_WIDTH;
    localparam int unsigned NUM_CLASSES = 1 << CLASS_WIDTH;

    typedef logic [CLASS_WIDTH-1:0] class_id_t;

    typedef enum logic {
        ST_IDLE,
        ST_DUMP
    } dump_state_t;

    function automatic class_id_t class_id(input logic [LEVEL_WIDTH-1:0] level,
                                           input logic [PATH_WIDTH-1:0]  path);
        return {level, path};
    endfunction

endpackage

// File: rtl/spike_class_counter_if.sv
// Report record link (valid/ready) from spike_class_counter to the host side.
interface spike_class_counter_if #(
    parameter int unsigned CLASS_WIDTH = dtree_pkg::CLASS_WIDTH,
    parameter int unsigned COUNT_WIDTH = 12
);

    logic                   rpt_valid;
    logic                   rpt_ready;
    logic [CLASS_WIDTH-1:0] rpt_class;
    logic [COUNT_WIDTH-1:0] rpt_count;
    logic                   rpt_last;

    modport master (
        output rpt_valid,
        output rpt_class,
        output rpt_count,
        output rpt_last,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_class,
        input  rpt_count,
        input  rpt_last,
        output rpt_ready
    );

endinterface

// File: rtl/spike_class_counter_bank.sv
// One bank of NUM_CLASSES saturating counters with increment, single clear,
// clear-all and combinational read.
module class_count_bank
    import dtree_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_inc,
    input  class_id_t              i_inc_idx,
    input  logic                   i_clr,
    input  class_id_t              i_clr_idx,
    input  logic                   i_clr_all,
    input  class_id_t              i_rd_idx,
    output logic [COUNT_WIDTH-1:0] o_rd_data
);

    logic [COUNT_WIDTH-1:0] r_cnt [NUM_CLASSES];

    // Clear-all wins so an increment landing on a discarded frame is dropped.
    always_ff @(posedge clk) begin
        if (reset || i_clr_all) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (i_inc && (r_cnt[i_inc_idx] != '1)) begin
                r_cnt[i_inc_idx] <= r_cnt[i_inc_idx] + 1'b1;
            end
            if (i_clr) begin
                r_cnt[i_clr_idx] <= '0;
            end
        end
    end

    assign o_rd_data = r_cnt[i_rd_idx];

endmodule

// File: rtl/spike_class_counter.sv
// Per-frame spike histogram over 16 leaf classes, double-banked so one frame
// is streamed out as class/count records while the next keeps counting.
module spike_class_counter #(
    parameter int unsigned FRAME_LEN   = 1000,
    parameter int unsigned COUNT_WIDTH = 12,
    parameter int unsigned LEVEL_WIDTH = 2,
    parameter int unsigned PATH_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   in_valid,
    input  logic [LEVEL_WIDTH-1:0] level,
    input  logic [PATH_WIDTH-1:0]  path,
    spike_class_counter_if.master  rpt,
    output logic                   frame_overrun,
    output logic                   busy
);

    import dtree_pkg::*;

    localparam int unsigned FRAME_CNT_W = $clog2(FRAME_LEN);

    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    dump_state_t            r_state;
    dump_state_t            w_state_nxt;
    class_id_t              r_idx;
    logic                   r_bank_sel;
    logic                   r_overrun;

    logic                   w_frame_end;
    logic                   w_swap;
    logic                   w_overrun_evt;
    logic                   w_hs;
    logic                   w_last_idx;
    class_id_t              w_class;
    logic [COUNT_WIDTH-1:0] w_rd_data [2];

    assign w_class       = class_id(level, path);
    assign w_frame_end   = sample_tick && (r_frame_cnt == FRAME_CNT_W'(FRAME_LEN - 1));
    assign w_swap        = w_frame_end && (r_state == ST_IDLE);
    assign w_overrun_evt = w_frame_end && (r_state == ST_DUMP);
    assign w_hs          = rpt.rpt_valid && rpt.rpt_ready;
    assign w_last_idx    = (r_idx == class_id_t'(NUM_CLASSES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (sample_tick) begin
            r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_frame_end)         w_state_nxt = ST_DUMP;
            ST_DUMP: if (w_hs && w_last_idx)  w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank_sel <= 1'b0;
            r_idx      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= w_overrun_evt;
            if (w_swap) begin
                r_bank_sel <= ~r_bank_sel;
                r_idx      <= '0;
            end else if (w_hs) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Physical bank r_bank_sel counts; the other one is being dumped.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_is_count;
        assign w_is_count = (r_bank_sel == 1'(b));

        class_count_bank #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .i_inc     (in_valid && w_is_count),
            .i_inc_idx (w_class),
            .i_clr     (w_hs && !w_is_count),
            .i_clr_idx (r_idx),
            .i_clr_all (w_overrun_evt && w_is_count),
            .i_rd_idx  (r_idx),
            .o_rd_data (w_rd_data[b])
        );
    end

    always_comb begin
        rpt.rpt_valid = (r_state == ST_DUMP);
        rpt.rpt_class = r_idx;
        rpt.rpt_count = r_bank_sel ? w_rd_data[0] : w_rd_data[1];
        rpt.rpt_last  = (r_state == ST_DUMP) && w_last_idx;
        busy          = (r_state == ST_DUMP);
        frame_overrun = r_overrun;
    end

endmodule

// File: tb/tb_spike_class_counter.sv
// Randomised bench for spike_class_counter against a frame-level histogram model.
module tb_spike_class_counter;

    import dtree_pkg::*;

    localparam int unsigned FRAME_LEN   = 20;
    localparam int unsigned COUNT_WIDTH = 4;
    localparam int          CNT_MAX     = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] level = 2'b00;
    logic [1:0] path = 2'b00;
    logic       frame_overrun;
    logic       busy;

    spike_class_counter_if #(.CLASS_WIDTH(4), .COUNT_WIDTH(COUNT_WIDTH)) rpt_if ();

    spike_class_counter #(
        .FRAME_LEN   (FRAME_LEN),
        .COUNT_WIDTH (COUNT_WIDTH),
        .LEVEL_WIDTH (2),
        .PATH_WIDTH  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .in_valid      (in_valid),
        .level         (level),
        .path          (path),
        .rpt           (rpt_if),
        .frame_overrun (frame_overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Model: running histogram of the open frame plus the queue of records owed to the host.
    int m_cnt [16];
    int m_ticks;
    int q_cls [$];
    int q_cnt [$];
    bit m_ovr;
    int obs_cls [$];
    int obs_cnt [$];
    int obs_last [$];

    function automatic logic [11:0] exp_out();
        bit v;
        logic [3:0] c, n;
        bit l;
        v = (q_cls.size() != 0);
        c = 4'h0; n = 4'h0; l = 1'b0;
        if (v) begin
            c = 4'(q_cls[0]);
            n = 4'(q_cnt[0]);
            l = (q_cls[0] == 15);
        end
        return {v, v, m_ovr, l, c, n};
    endfunction

    function automatic logic [11:0] act_out();
        return {rpt_if.rpt_valid, busy, frame_overrun, rpt_if.rpt_last,
                (rpt_if.rpt_valid ? rpt_if.rpt_class : 4'h0),
                (rpt_if.rpt_valid ? rpt_if.rpt_count : 4'h0)};
    endfunction

    task automatic model_reset();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_ticks = 0;
        m_ovr   = 1'b0;
        q_cls.delete(); q_cnt.delete();
        obs_cls.delete(); obs_cnt.delete(); obs_last.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_tick = 1'b0; in_valid = 1'b0;
        level = 2'b00; path = 2'b00; rpt_if.rpt_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit tick, input bit iv, input int cls, input bit rdy);
        bit dumping;
        int c;
        sample_tick = tick; in_valid = iv;
        level = 2'(cls >> 2); path = 2'(cls & 3);
        rpt_if.rpt_ready = rdy;
        if (rpt_if.rpt_valid === 1'b1 && rdy) begin
            obs_cls.push_back(int'(rpt_if.rpt_class));
            obs_cnt.push_back(int'(rpt_if.rpt_count));
            obs_last.push_back(int'(rpt_if.rpt_last));
        end
        @(posedge clk);
        dumping = (q_cls.size() != 0);
        if (dumping && rdy) begin
            void'(q_cls.pop_front());
            void'(q_cnt.pop_front());
        end
        c = int'(class_id(level, path));
        if (iv && m_cnt[c] < CNT_MAX) m_cnt[c]++;
        m_ovr = 1'b0;
        if (tick) begin
            if (m_ticks == FRAME_LEN - 1) begin
                m_ticks = 0;
                if (!dumping) begin
                    for (int k = 0; k < 16; k++) begin
                        q_cls.push_back(k);
                        q_cnt.push_back(m_cnt[k]);
                    end
                end else begin
                    m_ovr = 1'b1;
                end
                foreach (m_cnt[k]) m_cnt[k] = 0;
            end else begin
                m_ticks++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        tests++;
        if ({rpt_if.rpt_valid, rpt_if.rpt_last, frame_overrun, busy} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_outputs got valid/last/ovr/busy=%b want=0000",
                     {rpt_if.rpt_valid, rpt_if.rpt_last, frame_overrun, busy});
        end
        tests++;
        if (act_out() !== exp_out()) begin
            failed++;
            $display("FAIL reset_model got=%h want=%h", act_out(), exp_out());
        end
    endtask

    task automatic test_single_class();
        bit hit [20];
        int n;
        int r;
        do_reset();
        foreach (hit[k]) hit[k] = 1'b0;
        n = 0;
        while (n < 3) begin
            r = $urandom_range(0, 19);
            if (!hit[r]) begin hit[r] = 1'b1; n++; end
        end
        for (int i = 0; i < 36; i++) begin
            step(1'b1, (i < 20) && hit[i], 9, 1'b1);
            tests++;
            if (act_out() !== exp_out()) begin
                failed++;
                $display("FAIL single_cyc%0d got=%h want=%h", i, act_out(), exp_out());
            end
        end
        tests++;
        if (obs_cls.size() != 16) begin
            failed++;
            $display("FAIL single_nrec got=%0d want=16", obs_cls.size());
        end
        for (int k = 0; k < obs_cls.size(); k++) begin
            tests++;
            if (obs_cls[k] != k || obs_cnt[k] != ((k == 9) ? 3 : 0) || obs_last[k] != ((k == 15) ? 1 : 0)) begin
                failed++;
                $display("FAIL single_rec%0d got cls=%0d cnt=%0d last=%0d want cls=%0d cnt=%0d last=%0d",
                         k, obs_cls[k], obs_cnt[k], obs_last[k], k, (k == 9) ? 3 : 0, (k == 15) ? 1 : 0);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 36; i++) begin
            step(i < 20, i < 20, 5, 1'b1);
            tests++;
            if (act_out() !== exp_out()) begin
                failed++;
                $display("FAIL sat_cyc%0d got=%h want=%h", i, act_out(), exp_out());
            end
        end
        tests++;
        if (obs_cls.size() != 16) begin
            failed++;
            $display("FAIL sat_nrec got=%0d want=16", obs_cls.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (obs_cnt[k] != ((k == 5) ? 15 : 0)) begin
                    failed++;
                    $display("FAIL sat_cls%0d got=%0d want=%0d", k, obs_cnt[k], (k == 5) ? 15 : 0);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int tally [16];
        int iv, cls;
        do_reset();
        foreach (tally[k]) tally[k] = 0;
        for (int i = 0; i < 20; i++) begin
            iv  = $urandom_range(0, 1);
            cls = $urandom_range(0, 15);
            if (iv != 0) tally[cls]++;
            step(1'b1, iv != 0, cls, 1'b1);
        end
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 1'b0, 0, (i % 2) == 0);
            tests++;
            if (act_out() !== exp_out()) begin
                failed++;
                $display("FAIL bp_cyc%0d got=%h want=%h", i, act_out(), exp_out());
            end
        end
        tests++;
        if (obs_cls.size() != 16 || busy !== 1'b0) begin
            failed++;
            $display("FAIL bp_done got nrec=%0d busy=%b want nrec=16 busy=0", obs_cls.size(), busy);
        end
        for (int k = 0; k < obs_cls.size(); k++) begin
            tests++;
            if (obs_cls[k] != k || obs_cnt[k] != ((tally[k] > CNT_MAX) ? CNT_MAX : tally[k])) begin
                failed++;
                $display("FAIL bp_rec%0d got cls=%0d cnt=%0d want cls=%0d cnt=%0d",
                         k, obs_cls[k], obs_cnt[k], k, tally[k]);
            end
        end
    endtask

    task automatic test_overrun();
        int tally [16];
        int iv, cls, ovr_seen;
        do_reset();
        foreach (tally[k]) tally[k] = 0;
        ovr_seen = 0;
        for (int i = 0; i < 92; i++) begin
            if (i < 20) begin
                iv  = $urandom_range(0, 1);
                cls = $urandom_range(0, 15);
                if (iv != 0) tally[cls]++;
                step(1'b1, iv != 0, cls, 1'b0);
            end else if (i < 40) begin
                step(1'b1, 1'b1, $urandom_range(0, 15), 1'b0);
            end else begin
                step(i < 76, 1'b0, 0, 1'b1);
            end
            if (frame_overrun === 1'b1) ovr_seen++;
            tests++;
            if (act_out() !== exp_out()) begin
                failed++;
                $display("FAIL ovr_cyc%0d got=%h want=%h", i, act_out(), exp_out());
            end
        end
        tests++;
        if (ovr_seen != 1) begin
            failed++;
            $display("FAIL ovr_pulses got=%0d want=1", ovr_seen);
        end
        tests++;
        if (obs_cls.size() != 32) begin
            failed++;
            $display("FAIL ovr_nrec got=%0d want=32", obs_cls.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                tests++;
                if (obs_cnt[k] != ((k < 16) ? tally[k] : 0)) begin
                    failed++;
                    $display("FAIL ovr_rec%0d got=%0d want=%0d", k, obs_cnt[k], (k < 16) ? tally[k] : 0);
                end
            end
        end
    endtask

    task automatic test_boundary();
        do_reset();
        for (int i = 0; i < 56; i++) begin
            step(i < 40, i == 19, 0, 1'b1);
            tests++;
            if (act_out() !== exp_out()) begin
                failed++;
                $display("FAIL bnd_cyc%0d got=%h want=%h", i, act_out(), exp_out());
            end
        end
        tests++;
        if (obs_cls.size() != 32) begin
            failed++;
            $display("FAIL bnd_nrec got=%0d want=32", obs_cls.size());
        end else begin
            tests++;
            if (obs_cnt[0] != 1 || obs_cnt[16] != 0) begin
                failed++;
                $display("FAIL bnd_class0 got first=%0d next=%0d want first=1 next=0", obs_cnt[0], obs_cnt[16]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            step(i < 20, 1'b1, $urandom_range(4, 15), 1'b1);
        end
        tests++;
        if (obs_cls.size() != 5) begin
            failed++;
            $display("FAIL rmd_pre got=%0d want=5", obs_cls.size());
        end
        reset = 1'b1; sample_tick = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({rpt_if.rpt_valid, rpt_if.rpt_last, frame_overrun, busy} !== 4'b0000) begin
            failed++;
            $display("FAIL rmd_outputs got=%b want=0000",
                     {rpt_if.rpt_valid, rpt_if.rpt_last, frame_overrun, busy});
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 36; i++) begin
            step(i < 20, (i == 4) || (i == 11), 3, 1'b1);
            tests++;
            if (act_out() !== exp_out()) begin
                failed++;
                $display("FAIL rmd_cyc%0d got=%h want=%h", i, act_out(), exp_out());
            end
        end
        tests++;
        if (obs_cls.size() != 16) begin
            failed++;
            $display("FAIL rmd_nrec got=%0d want=16", obs_cls.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                tests++;
                if (obs_cnt[k] != ((k == 3) ? 2 : 0)) begin
                    failed++;
                    $display("FAIL rmd_cls%0d got=%0d want=%0d", k, obs_cnt[k], (k == 3) ? 2 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 15), $urandom_range(0, 9) < 7);
            tests++;
            if (act_out() !== exp_out()) begin
                failed++;
                $display("FAIL rand_cyc%0d got=%h want=%h", i, act_out(), exp_out());
            end
        end
    endtask

    initial begin
        rpt_if.rpt_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_class();
        test_saturation();
        test_backpressure();
        test_overrun();
        test_boundary();
        test_reset_mid_dump();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
